// File: rtl/cv32e40p_rf_scrub_pkg.sv
// Shared types and address constants for the register-file parity scrubber.
package cv32e40p_rf_scrub_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        READ    = 2'd2,
        CONFIRM = 2'd3
    } scrub_state_e;

    localparam int unsigned RF_NUM_INT    = 32;
    localparam int unsigned RF_NUM_FP     = 32;
    localparam int unsigned FIRST_ADDR    = 1;
    localparam int unsigned LAST_INT_ADDR = RF_NUM_INT - 1;
    localparam int unsigned LAST_FP_ADDR  = RF_NUM_INT + RF_NUM_FP - 1;

endpackage

// File: rtl/cv32e40p_sat_counter.sv
// Saturating up-counter with synchronous clear; a clear coinciding with an
// increment leaves the count at one.
module cv32e40p_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= inc ? CNT_W'(1) : '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/cv32e40p_rf_parity_scrubber.sv
// Background parity scrubber for the register file, using idle cycles of a spare read port.
// Define RF_SCRUB_FP_EN to extend the sweep over the FP bank.
module cv32e40p_rf_parity_scrubber
    import cv32e40p_rf_scrub_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_INT    = LAST_INT_ADDR + 1,
    parameter int unsigned NUM_FP     = LAST_FP_ADDR - LAST_INT_ADDR,
    parameter int unsigned INTERVAL_W = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic [INTERVAL_W-1:0] interval_i,
    input  logic                  port_free_i,
    output logic                  scrub_req_o,
    output logic [ADDR_WIDTH-1:0] scrub_raddr_o,
    input  logic                  scrub_par_ok_i,
    input  logic                  err_clear_i,
    output logic                  err_valid_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [CNT_W-1:0]      err_count_o,
    output logic [CNT_W-1:0]      trans_count_o,
    output logic                  err_irq_o,
    output logic                  sweep_done_o,
    output logic                  busy_o
);

`ifdef RF_SCRUB_FP_EN
    localparam bit FP_EN = 1'b1;
`else
    localparam bit FP_EN = 1'b0;
`endif

    localparam int unsigned LAST_PTR = FP_EN ? (NUM_INT + NUM_FP - 1) : (NUM_INT - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_A = ADDR_WIDTH'(FIRST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(LAST_PTR);

    scrub_state_e          state, state_next;
    logic [INTERVAL_W-1:0] wait_cnt, wait_cnt_next;
    logic [ADDR_WIDTH-1:0] ptr, ptr_next;
    logic                  grant, advance, err_hit, trans_hit;

    // Dropping enable releases the port in the same cycle, so any grant then is ignored.
    assign scrub_req_o = enable_i && ((state == READ) || (state == CONFIRM));
    assign grant       = scrub_req_o && port_free_i;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        advance       = 1'b0;
        err_hit       = 1'b0;
        trans_hit     = 1'b0;
        if (!enable_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next    = WAIT;
                    wait_cnt_next = interval_i;
                end
                WAIT: begin
                    if (wait_cnt <= INTERVAL_W'(1)) state_next = READ;
                    if (wait_cnt != '0) wait_cnt_next = wait_cnt - 1'b1;
                end
                READ: begin
                    if (grant) begin
                        if (scrub_par_ok_i) begin
                            advance       = 1'b1;
                            state_next    = WAIT;
                            wait_cnt_next = interval_i;
                        end else begin
                            state_next = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (grant) begin
                        advance       = 1'b1;
                        state_next    = WAIT;
                        wait_cnt_next = interval_i;
                        trans_hit     = scrub_par_ok_i;
                        err_hit       = !scrub_par_ok_i;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        ptr_next = ptr;
        if (advance) ptr_next = (ptr == LAST_A) ? FIRST_A : ptr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            ptr          <= FIRST_A;
            sweep_done_o <= 1'b0;
        end else begin
            state        <= state_next;
            wait_cnt     <= wait_cnt_next;
            ptr          <= ptr_next;
            sweep_done_o <= advance && (ptr == LAST_A);
        end
    end

    // A new error in the clearing cycle is logged as the first error after the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
        end else if (err_hit && (!err_valid_o || err_clear_i)) begin
            err_valid_o <= 1'b1;
            err_addr_o  <= ptr;
        end else if (err_clear_i) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
        end
    end

    cv32e40p_sat_counter #(.CNT_W(CNT_W)) u_err_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_hit),
        .clr   (err_clear_i),
        .q     (err_count_o)
    );

    cv32e40p_sat_counter #(.CNT_W(CNT_W)) u_trans_count (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (trans_hit),
        .clr   (err_clear_i),
        .q     (trans_count_o)
    );

    assign scrub_raddr_o = ptr;
    assign err_irq_o     = err_valid_o;
    assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_cv32e40p_rf_parity_scrubber.sv
// Directed bench for the register-file parity scrubber: cycle table plus hand sequences.
module tb_cv32e40p_rf_parity_scrubber;

`ifdef RF_SCRUB_FP_EN
    localparam int LAST = 63;
`else
    localparam int LAST = 31;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en, pf, ok, clr;
    logic [15:0] iv;
    logic        req, ev, irq, sd, busy;
    logic [5:0]  raddr, ea;
    logic [7:0]  ec, tc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40p_rf_parity_scrubber dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (en),
        .interval_i     (iv),
        .port_free_i    (pf),
        .scrub_req_o    (req),
        .scrub_raddr_o  (raddr),
        .scrub_par_ok_i (ok),
        .err_clear_i    (clr),
        .err_valid_o    (ev),
        .err_addr_o     (ea),
        .err_count_o    (ec),
        .trans_count_o  (tc),
        .err_irq_o      (irq),
        .sweep_done_o   (sd),
        .busy_o         (busy)
    );

    typedef struct {
        logic        en;
        logic [15:0] iv;
        logic        pf, ok, clr;
        logic        req;
        logic [5:0]  raddr;
        logic        busy, ev;
        logic [5:0]  ea;
        logic [7:0]  ec, tc;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic e, input logic [15:0] i, input logic p, input logic o,
                                input logic c, input logic r, input logic [5:0] a, input logic b,
                                input logic v, input logic [5:0] x, input logic [7:0] n,
                                input logic [7:0] t);
        vec_t m;
        m.en = e; m.iv = i; m.pf = p; m.ok = o; m.clr = c;
        m.req = r; m.raddr = a; m.busy = b; m.ev = v; m.ea = x; m.ec = n; m.tc = t;
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge and settle before sampling.
    task automatic cyc(input logic e, input logic [15:0] i, input logic p, input logic o, input logic c);
        @(negedge clk);
        en = e; iv = i; pf = p; ok = o; clr = c;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en = 1'b0; iv = '0; pf = 1'b0; ok = 1'b1; clr = 1'b0;
        #1;
        check("rst_req", req, 0);
        check("rst_raddr", raddr, 1);
        check("rst_busy", busy, 0);
        check("rst_ev", ev, 0);
        check("rst_irq", irq, 0);
        check("rst_ea", ea, 0);
        check("rst_ec", ec, 0);
        check("rst_tc", tc, 0);
        check("rst_sd", sd, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Return in the READ cycle of the target (any address if target < 0), inputs still adjustable.
    task automatic wait_read(input int target);
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
            if (req === 1'b1 && (target < 0 || int'(raddr) == target)) found = 1'b1;
        end
        check($sformatf("reach_read_%0d", target), found, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_addr, sd_cnt, last_read;
        en = 1'b0; iv = '0; pf = 1'b0; ok = 1'b1; clr = 1'b0;

        //            en iv pf ok clr req ad busy ev ea ec tc
        vecs[0]  = mk(0, 0, 1, 1, 0,  0, 1, 0,  0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 1, 1, 0,  0, 1, 0,  0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 1, 1, 0,  0, 1, 1,  0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 1, 0,  1, 1, 1,  0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0,  1, 1, 1,  0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 1, 1, 0,  1, 1, 1,  0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 1, 1, 0,  0, 2, 1,  0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 1, 0, 0,  1, 2, 1,  0, 0, 0, 0);
        vecs[8]  = mk(1, 0, 1, 0, 0,  1, 2, 1,  0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 1, 1, 0,  0, 3, 1,  1, 2, 1, 0);
        vecs[10] = mk(1, 0, 1, 0, 0,  1, 3, 1,  1, 2, 1, 0);
        vecs[11] = mk(1, 0, 1, 1, 0,  1, 3, 1,  1, 2, 1, 0);
        vecs[12] = mk(1, 0, 1, 1, 0,  0, 4, 1,  1, 2, 1, 1);
        vecs[13] = mk(1, 0, 1, 0, 0,  1, 4, 1,  1, 2, 1, 1);
        vecs[14] = mk(1, 0, 1, 0, 0,  1, 4, 1,  1, 2, 1, 1);
        vecs[15] = mk(1, 0, 1, 1, 1,  0, 5, 1,  1, 2, 2, 1);
        vecs[16] = mk(0, 0, 1, 1, 0,  0, 5, 1,  0, 0, 0, 0);
        vecs[17] = mk(0, 0, 1, 1, 0,  0, 5, 0,  0, 0, 0, 0);
        vecs[18] = mk(1, 2, 1, 1, 0,  0, 5, 0,  0, 0, 0, 0);
        vecs[19] = mk(1, 2, 1, 1, 0,  0, 5, 1,  0, 0, 0, 0);
        vecs[20] = mk(1, 2, 1, 1, 0,  0, 5, 1,  0, 0, 0, 0);
        vecs[21] = mk(1, 2, 1, 1, 0,  1, 5, 1,  0, 0, 0, 0);
        vecs[22] = mk(1, 2, 1, 1, 0,  0, 6, 1,  0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 23; i++) begin
            cyc(vecs[i].en, vecs[i].iv, vecs[i].pf, vecs[i].ok, vecs[i].clr);
            check($sformatf("v%0d_req", i), req, vecs[i].req);
            check($sformatf("v%0d_raddr", i), raddr, vecs[i].raddr);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_ev", i), ev, vecs[i].ev);
            check($sformatf("v%0d_irq", i), irq, vecs[i].ev);
            check($sformatf("v%0d_ea", i), ea, vecs[i].ea);
            check($sformatf("v%0d_ec", i), ec, vecs[i].ec);
            check($sformatf("v%0d_tc", i), tc, vecs[i].tc);
            check($sformatf("v%0d_sd", i), sd, 0);
        end

        // Full sweep, interval 0, everything clean.
        do_reset();
        exp_addr = 1; sd_cnt = 0; last_read = -1;
        for (int k = 0; k < 2 * LAST + 4; k++) begin
            cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
            if (sd === 1'b1) begin
                sd_cnt++;
                check("sweep_done_after_last", last_read, LAST);
            end
            if (req === 1'b1) begin
                check("sweep_addr", raddr, exp_addr);
                last_read = int'(raddr);
                exp_addr = (exp_addr == LAST) ? 1 : exp_addr + 1;
            end
        end
        check("sweep_done_count", sd_cnt, 1);
        check("sweep_wrapped", exp_addr, 2);
        check("sweep_ev", ev, 0);

        // Stored error at 7.
        do_reset();
        wait_read(7);
        ok = 1'b0;
        cyc(1'b1, 16'd0, 1'b1, 1'b0, 1'b0);
        check("stored_confirm_req", req, 1);
        check("stored_confirm_addr", raddr, 7);
        cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        check("stored_ev", ev, 1);
        check("stored_ea", ea, 7);
        check("stored_ec", ec, 1);
        check("stored_irq", irq, 1);
        cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        check("stored_next_req", req, 1);
        check("stored_next_addr", raddr, 8);

        // Transient mismatch at 12.
        do_reset();
        wait_read(12);
        ok = 1'b0;
        cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        check("trans_confirm_addr", raddr, 12);
        cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        check("trans_tc", tc, 1);
        check("trans_ev", ev, 0);
        check("trans_irq", irq, 0);
        check("trans_ec", ec, 0);
        cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        check("trans_next_addr", raddr, 13);

        // Port held by ID for 20 cycles while reading 4.
        do_reset();
        wait_read(4);
        pf = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 16'd0, 1'b0, 1'b1, 1'b0);
            check("arb_req", req, 1);
            check("arb_addr", raddr, 4);
        end
        cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        check("arb_grant_req", req, 1);
        check("arb_grant_addr", raddr, 4);
        cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        check("arb_after_req", req, 0);
        check("arb_after_addr", raddr, 5);

        // Clear coinciding with a confirmed error at 20, earlier log at 3.
        do_reset();
        wait_read(3);
        ok = 1'b0;
        cyc(1'b1, 16'd0, 1'b1, 1'b0, 1'b0);
        wait_read(20);
        check("race_prior_ea", ea, 3);
        check("race_prior_ec", ec, 1);
        ok = 1'b0;
        cyc(1'b1, 16'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        check("race_ev", ev, 1);
        check("race_ea", ea, 20);
        check("race_ec", ec, 1);

        // 300 more confirmed errors saturate the 8-bit count.
        for (int k = 0; k < 300; k++) begin
            wait_read(-1);
            ok = 1'b0;
            cyc(1'b1, 16'd0, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b1, 16'd0, 1'b1, 1'b1, 1'b0);
        check("sat_ec", ec, 255);
        check("sat_ea", ea, 20);

        // Pause in CONFIRM at 15, resume with interval 3.
        do_reset();
        wait_read(15);
        ok = 1'b0;
        cyc(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
        check("pause_req", req, 0);
        check("pause_addr", raddr, 15);
        check("pause_busy", busy, 1);
        cyc(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
        check("pause_idle_busy", busy, 0);
        check("pause_ec", ec, 0);
        check("pause_ev", ev, 0);
        cyc(1'b1, 16'd3, 1'b1, 1'b1, 1'b0);
        check("resume_idle_busy", busy, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 16'd3, 1'b1, 1'b1, 1'b0);
            check("resume_wait_req", req, 0);
            check("resume_wait_busy", busy, 1);
        end
        cyc(1'b1, 16'd3, 1'b1, 1'b1, 1'b0);
        check("resume_req", req, 1);
        check("resume_addr", raddr, 15);
        check("resume_tc", tc, 0);

        do_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
